// File: rtl/v_mem_arb.sv
// Round-robin arbiter for core v's single memory port. One transaction is in
// flight at a time: accept -> issue downstream -> wait for response -> route back.
//
// state   | meaning
// IDLE    | no transaction; round-robin search over req_vld_i, accept winner
// ISSUE   | latched request presented downstream until mem_req_rdy_i
// WAIT    | request handed off; waiting for mem_rsp_vld_i
module v_mem_arb #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_vld_i,
    input  logic [N_REQ-1:0]        req_wr_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]        req_rdy_o,
    output logic                    mem_req_vld_o,
    input  logic                    mem_req_rdy_i,
    output logic                    mem_req_wr_o,
    output logic [ADDR_W-1:0]       mem_req_addr_o,
    output logic [DATA_W-1:0]       mem_req_wdata_o,
    input  logic                    mem_rsp_vld_i,
    input  logic [DATA_W-1:0]       mem_rsp_rdata_i,
    output logic [N_REQ-1:0]        rsp_vld_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ_W  = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic               r_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [N_REQ-1:0]   r_rsp_vld;
    logic               r_err;

    logic [2*N_REQ-1:0] w_vld_dbl;
    logic [2*N_REQ-1:0] w_vld_rot;
    logic [PTR_W-1:0]   w_off;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_winner;
    logic               w_any;
    logic [N_REQ-1:0]   w_grant;
    logic               w_sel_wr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [PTR_W-1:0]   w_ptr_next;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest
    // set bit of the rotated view is the round-robin winner's offset.
    always_comb begin
        w_vld_dbl = {req_vld_i, req_vld_i};
        w_vld_rot = w_vld_dbl >> r_rr_ptr;
        w_off     = '0;
        w_any     = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_vld_rot[k]) begin
                w_any = 1'b1;
                w_off = PTR_W'(k);
            end
        end
        w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_winner = (w_sum >= NREQ_W) ? PTR_W'(w_sum - NREQ_W) : w_sum[PTR_W-1:0];
        w_grant  = w_any ? (N_REQ'(1) << w_winner) : '0;
    end

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_sel_wr    = req_wr_i[i];
                w_sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (r_owner == PTR_MAX) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rsp_vld <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rsp_vld <= '0;
            if (mem_rsp_vld_i && (r_state != S_WAIT))
                r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_winner;
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_rdy_i)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_vld_i) begin
                        r_rdata   <= mem_rsp_rdata_i;
                        r_rsp_vld <= N_REQ'(1) << r_owner;
                        r_rr_ptr  <= w_ptr_next;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by rst so no accept strobe escapes while the arbiter is held in reset.
    assign req_rdy_o       = ((r_state == S_IDLE) && rst) ? w_grant : '0;
    assign mem_req_vld_o   = (r_state == S_ISSUE);
    assign mem_req_wr_o    = r_wr;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_wdata_o = r_wdata;
    assign rsp_vld_o       = r_rsp_vld;
    assign rsp_rdata_o     = r_rdata;
    assign busy_o          = (r_state != S_IDLE);
    assign err_o           = r_err;

endmodule

// File: tb/tb_v_mem_arb.sv
// Bench for v_mem_arb: arbitration vector table, directed multi-cycle sequences,
// and a randomized run against a transaction-level round-robin model.
module tb_v_mem_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld, req_wr, req_rdy, rsp_vld;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            mem_req_vld, mem_req_rdy, mem_req_wr, mem_rsp_vld, busy, err;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata, mem_rsp_rdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    v_mem_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld), .req_wr_i(req_wr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_rdy_o(req_rdy),
        .mem_req_vld_o(mem_req_vld), .mem_req_rdy_i(mem_req_rdy), .mem_req_wr_o(mem_req_wr),
        .mem_req_addr_o(mem_req_addr), .mem_req_wdata_o(mem_req_wdata),
        .mem_rsp_vld_i(mem_rsp_vld), .mem_rsp_rdata_i(mem_rsp_rdata),
        .rsp_vld_o(rsp_vld), .rsp_rdata_o(rsp_rdata),
        .busy_o(busy), .err_o(err)
    );

    typedef struct {
        int           setup;   // requester completing a txn first, -1 = none
        logic [N-1:0] vld;
        logic [N-1:0] exp;
    } arb_vec_t;

    arb_vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx = (ptr + k) % N;
            if (v[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    task automatic idle_inputs();
        req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_memvld", mem_req_vld, 0);
        chk("rst_rsp", rsp_vld, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic txn(input int r, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                       input int stall, input int rdelay);
        logic [N-1:0] oh;
        oh = N'(1) << r;
        @(negedge clk);
        req_vld = oh;
        req_wr[r] = wr;
        req_addr[r*AW +: AW] = addr;
        req_wdata[r*DW +: DW] = wdata;
        #2;
        chk("acc_rdy", req_rdy, oh);
        chk("acc_busy", busy, 0);
        chk("acc_memvld", mem_req_vld, 0);
        @(negedge clk);
        req_vld = '0;
        mem_req_rdy = (stall == 0);
        #2;
        chk("iss_vld", mem_req_vld, 1);
        chk("iss_addr", mem_req_addr, addr);
        chk("iss_wr", mem_req_wr, wr);
        chk("iss_wdata", mem_req_wdata, wdata);
        chk("iss_rdy0", req_rdy, 0);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            mem_req_rdy = (s == stall);
            #2;
            chk("stall_vld", mem_req_vld, 1);
            chk("stall_addr", mem_req_addr, addr);
            chk("stall_wdata", mem_req_wdata, wdata);
        end
        for (int d = 1; d <= rdelay; d++) begin
            @(negedge clk);
            mem_req_rdy = 1'b0;
            mem_rsp_vld = (d == rdelay);
            mem_rsp_rdata = rdata;
            #2;
            chk("wait_memvld", mem_req_vld, 0);
            chk("wait_busy", busy, 1);
            chk("wait_rsp", rsp_vld, 0);
        end
        @(negedge clk);
        mem_rsp_vld = 1'b0;
        #2;
        chk("rsp_oh", rsp_vld, oh);
        if (!wr) chk("rsp_data", rsp_rdata, rdata);
        chk("rsp_busy", busy, 0);
    endtask

    task automatic run_random(input int cycles);
        int m_ptr = 0, m_owner = 0, m_cnt = 0;
        bit m_inflight = 0, m_req_out = 0, m_wait = 0, s_wr = 0, m_exp_wr = 0;
        logic [N-1:0] p_vld = '0, m_exp_rsp = '0, exp_rdy;
        logic [AW-1:0] s_addr = '0;
        logic [DW-1:0] s_wdata = '0, m_exp_data = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!p_vld[i] && $urandom_range(0, 2) == 0) begin
                    p_vld[i] = 1'b1;
                    req_wr[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = $urandom;
                    req_wdata[i*DW +: DW] = $urandom;
                end
            end
            req_vld = p_vld;
            mem_req_rdy = 1'($urandom_range(0, 1));
            mem_rsp_vld = 1'b0;
            if (m_wait) begin
                if (m_cnt == 0) mem_rsp_vld = 1'b1;
                else m_cnt--;
            end
            mem_rsp_rdata = $urandom;
            #2;
            exp_rdy = m_inflight ? '0 : rr_pick(p_vld, m_ptr);
            chk("rnd_rdy", req_rdy, exp_rdy);
            chk("rnd_busy", busy, m_inflight);
            chk("rnd_memvld", mem_req_vld, m_req_out);
            if (m_req_out) begin
                chk("rnd_addr", mem_req_addr, s_addr);
                chk("rnd_wr", mem_req_wr, s_wr);
                chk("rnd_wdata", mem_req_wdata, s_wdata);
            end
            chk("rnd_rsp", rsp_vld, m_exp_rsp);
            if (m_exp_rsp != '0 && !m_exp_wr) chk("rnd_rdata", rsp_rdata, m_exp_data);
            chk("rnd_err", err, 0);
            m_exp_rsp = '0;
            if (mem_rsp_vld) begin
                m_exp_rsp = N'(1) << m_owner;
                m_exp_data = mem_rsp_rdata;
                m_exp_wr = s_wr;
                m_inflight = 0;
                m_wait = 0;
                m_ptr = (m_owner + 1) % N;
            end
            if (m_req_out && mem_req_rdy) begin
                m_req_out = 0;
                m_wait = 1;
                m_cnt = $urandom_range(0, 3);
            end
            if (exp_rdy != '0) begin
                for (int k = 0; k < N; k++) if (exp_rdy[k]) m_owner = k;
                s_addr = req_addr[m_owner*AW +: AW];
                s_wdata = req_wdata[m_owner*DW +: DW];
                s_wr = req_wr[m_owner];
                p_vld[m_owner] = 1'b0;
                m_inflight = 1;
                m_req_out = 1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] exp;
        vecs[0] = '{-1, 2'b00, 2'b00};
        vecs[1] = '{-1, 2'b01, 2'b01};
        vecs[2] = '{-1, 2'b10, 2'b10};
        vecs[3] = '{-1, 2'b11, 2'b01};
        vecs[4] = '{ 0, 2'b11, 2'b10};
        vecs[5] = '{ 0, 2'b01, 2'b01};
        vecs[6] = '{ 0, 2'b10, 2'b10};
        vecs[7] = '{ 1, 2'b11, 2'b01};
        vecs[8] = '{ 1, 2'b10, 2'b10};

        rst = 1'b0;
        idle_inputs();
        #1;
        chk("por_busy", busy, 0);
        chk("por_rdy", req_rdy, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (vecs[i].setup >= 0) txn(vecs[i].setup, 1'b0, 32'h10, 32'h0, 32'h1, 0, 1);
            @(negedge clk);
            req_vld = vecs[i].vld;
            #2;
            chk($sformatf("arb_vec%0d", i), req_rdy, vecs[i].exp);
        end

        // single read on req1, response two cycles after handshake
        do_reset();
        txn(1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2);
        @(negedge clk);
        #2;
        chk("rd_pulse1", rsp_vld, 0);
        chk("rd_hold", rsp_rdata, 32'hDEADBEEF);

        // both requesters always valid: grants alternate, next accept shares rsp cycle
        do_reset();
        @(negedge clk);
        req_vld = 2'b11;
        #2;
        for (int k = 0; k < 8; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            chk("alt_grant", req_rdy, exp);
            @(negedge clk);
            mem_req_rdy = 1'b1;
            #2;
            @(negedge clk);
            mem_req_rdy = 1'b0;
            mem_rsp_vld = 1'b1;
            mem_rsp_rdata = DW'(k + 32'hA0);
            #2;
            @(negedge clk);
            mem_rsp_vld = 1'b0;
            #2;
            chk("alt_rsp", rsp_vld, exp);
            chk("alt_rdata", rsp_rdata, DW'(k + 32'hA0));
        end

        // downstream stalls 5 cycles, then a write
        do_reset();
        txn(0, 1'b0, 32'h200, 32'h55, 32'h77, 5, 1);
        @(negedge clk);
        #2;
        chk("stall_one_rsp", rsp_vld, 0);
        chk("stall_no_reissue", mem_req_vld, 0);
        txn(0, 1'b1, 32'h40, 32'h12345678, 32'h0, 0, 1);

        // stray response while idle
        do_reset();
        @(negedge clk);
        #2;
        chk("err_pre", err, 0);
        @(negedge clk);
        mem_rsp_vld = 1'b1;
        mem_rsp_rdata = 32'hBAD;
        #2;
        @(negedge clk);
        mem_rsp_vld = 1'b0;
        #2;
        chk("err_no_rsp", rsp_vld, 0);
        chk("err_set", err, 1);
        txn(1, 1'b0, 32'h44, 32'h0, 32'h99, 1, 1);
        #1;
        chk("err_sticky", err, 1);

        // reset during WAIT drops the transaction
        do_reset();
        @(negedge clk);
        req_vld = 2'b10;
        req_addr[AW +: AW] = 32'h300;
        #2;
        chk("mid_acc", req_rdy, 2'b10);
        @(negedge clk);
        req_vld = '0;
        mem_req_rdy = 1'b1;
        @(negedge clk);
        mem_req_rdy = 1'b0;
        #2;
        chk("mid_wait", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        req_vld = 2'b11;
        #2;
        chk("mid_rst_rdy", req_rdy, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_memvld", mem_req_vld, 0);
        chk("mid_rst_addr", mem_req_addr, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        req_vld = '0;
        @(negedge clk);
        mem_rsp_vld = 1'b1;
        #2;
        @(negedge clk);
        mem_rsp_vld = 1'b0;
        #2;
        chk("mid_no_rsp", rsp_vld, 0);
        chk("mid_err", err, 1);
        @(negedge clk);
        req_vld = 2'b11;
        #2;
        chk("mid_next_grant", req_rdy, 2'b01);

        do_reset();
        run_random(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
